// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter plus 8N1 serialiser sharing one UART TX line.
//
// Ports:
//   i_clock  - system clock
//   i_reset  - synchronous, active-high reset
//   i_tick   - one-cycle pulse at OVERSAMPLE x baud rate
//   i_req    - per-requester send request (level, held until granted)
//   i_data   - flattened request bytes, requester k at [k*NB_DATA +: NB_DATA]
//   o_grant  - one-hot, one-cycle pulse when a byte is captured
//   o_owner  - index of the last granted requester
//   o_busy   - high while a frame is in progress
//   o_tx     - serial output, idle high
module uart_tx_scheduler #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16,
  localparam int unsigned OwnerW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_tick,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*NB_DATA-1:0]   i_data,
  output logic [N_REQ-1:0]           o_grant,
  output logic [OwnerW-1:0]          o_owner,
  output logic                       o_busy,
  output logic                       o_tx
);

  localparam int unsigned MaxTick = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned CntW    = $clog2(MaxTick) + 1;
  localparam int unsigned BitW    = $clog2(NB_DATA) + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic [CntW-1:0]      tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [NB_DATA-1:0]   shreg_q;
  logic [OwnerW-1:0]    ptr_q;
  logic [OwnerW-1:0]    owner_q;
  logic [N_REQ-1:0]     grant_q;
  logic                 busy_q;
  logic                 tx_q;

  // Round-robin winner: first set request searching upward from ptr_q, wrapping.
  logic                 win_found;
  logic [OwnerW-1:0]    win_idx;
  logic [OwnerW-1:0]    win_next;
  logic [N_REQ-1:0]     win_onehot;
  logic [NB_DATA-1:0]   win_data;
  logic [N_REQ-1:0]     req_shr;
  logic [N_REQ*NB_DATA-1:0] data_shr;
  logic [NB_DATA-1:0]   shreg_nxt;
  int unsigned          k;

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_next   = '0;
    win_onehot = '0;
    win_data   = '0;
    req_shr    = '0;
    data_shr   = '0;
    k          = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      req_shr  = i_req >> k;
      data_shr = i_data >> (k * NB_DATA);
      if (!win_found && req_shr[0]) begin
        win_found  = 1'b1;
        win_idx    = OwnerW'(k);
        win_next   = (k + 1 == N_REQ) ? '0 : OwnerW'(k + 1);
        win_onehot = N_REQ'(1) << k;
        win_data   = data_shr[NB_DATA-1:0];
      end
    end
  end

  assign shreg_nxt = shreg_q >> 1;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      grant_q <= '0;
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (win_found) begin
            shreg_q    <= win_data;
            grant_q    <= win_onehot;
            owner_q    <= win_idx;
            ptr_q      <= win_next;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
            tx_q       <= 1'b0;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (i_tick) begin
            if (tick_cnt_q == CntW'(OVERSAMPLE - 1)) begin
              tick_cnt_q <= '0;
              tx_q       <= shreg_q[0];
              state_q    <= StData;
            end else begin
              tick_cnt_q <= tick_cnt_q + CntW'(1);
            end
          end
        end
        StData: begin
          if (i_tick) begin
            if (tick_cnt_q == CntW'(OVERSAMPLE - 1)) begin
              tick_cnt_q <= '0;
              shreg_q    <= shreg_nxt;
              if (bit_cnt_q == BitW'(NB_DATA - 1)) begin
                bit_cnt_q <= '0;
                tx_q      <= 1'b1;
                state_q   <= StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + BitW'(1);
                tx_q      <= shreg_nxt[0];
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CntW'(1);
            end
          end
        end
        StStop: begin
          if (i_tick) begin
            if (tick_cnt_q == CntW'(SB_TICK - 1)) begin
              tick_cnt_q <= '0;
              busy_q     <= 1'b0;
              state_q    <= StIdle;
            end else begin
              tick_cnt_q <= tick_cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_grant = grant_q;
  assign o_owner = owner_q;
  assign o_busy  = busy_q;
  assign o_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: directed stimulus with a grant/byte scoreboard.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_tick = 1'b0;
  logic [1:0]  i_req = 2'b00;
  logic [15:0] i_data = 16'h0000;
  logic [1:0]  o_grant;
  logic        o_owner;
  logic        o_busy;
  logic        o_tx;

  int checks = 0;
  int errors = 0;
  bit tick_en = 1'b1;

  int         exp_grant[$];
  logic [7:0] exp_byte[$];

  uart_tx_scheduler #(
    .N_REQ(2), .NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)
  ) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_tick (i_tick),
    .i_req  (i_req),
    .i_data (i_data),
    .o_grant(o_grant),
    .o_owner(o_owner),
    .o_busy (o_busy),
    .o_tx   (o_tx)
  );

  always #5 clk = ~clk;

  // Tick every 4 cycles while enabled.
  initial begin
    int n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      i_tick = tick_en && (n % 4 == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant monitor.
  always @(negedge clk) begin
    if (!i_reset && o_grant != 2'b00) begin
      int e;
      logic [1:0] ev;
      checks++;
      if (exp_grant.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got grant %b with no grant expected", o_grant);
      end else begin
        e  = exp_grant.pop_front();
        ev = 2'b01 << e;
        if (o_grant !== ev || o_owner !== 1'(e)) begin
          errors++;
          $display("FAIL grant: got grant %b owner %0d expected grant %b owner %0d",
                   o_grant, o_owner, ev, e);
        end
      end
    end
  end

  // Serial decoder: counts the bench ticks and samples each bit mid-period.
  bit         tx_prev = 1'b1;
  bit         rx_active = 1'b0;
  bit         rx_bad;
  int         rx_ticks;
  int         rk;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (i_reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx_prev && !o_tx) begin
        rx_active = 1'b1;
        rx_bad    = 1'b0;
        rx_ticks  = i_tick ? 1 : 0;
      end
    end else if (i_tick) begin
      rx_ticks++;
      if (rx_ticks % 16 == 8) begin
        rk = rx_ticks / 16;
        if (rk == 0) begin
          if (o_tx !== 1'b0) rx_bad = 1'b1;
        end else if (rk <= 8) begin
          rx_byte[rk-1] = o_tx;
        end else begin
          if (o_tx !== 1'b1) rx_bad = 1'b1;
          rx_active = 1'b0;
          checks++;
          if (exp_byte.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got byte %h with no byte expected", rx_byte);
          end else begin
            logic [7:0] eb;
            eb = exp_byte.pop_front();
            if (rx_byte !== eb || rx_bad) begin
              errors++;
              $display("FAIL serial_byte: got %h (framing_bad=%0d) expected %h",
                       rx_byte, rx_bad, eb);
            end
          end
        end
      end
    end
    tx_prev = o_tx;
  end

  task automatic wait_grant(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (o_grant != 2'b00) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant expected one within %0d cycles", max);
    end
  endtask

  task automatic wait_idle(input int max, output int cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      cycles++;
      if (!o_busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy still high expected low within %0d cycles", max);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1 i_reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 i_reset = 1'b0;
  endtask

  initial begin
    int cyc;
    bit held;

    // Reset state.
    do_reset(3);
    @(negedge clk);
    check("reset_tx", 32'(o_tx), 1);
    check("reset_busy", 32'(o_busy), 0);
    check("reset_grant", 32'(o_grant), 0);
    check("reset_owner", 32'(o_owner), 0);

    // Single send of A5 and frame timing.
    exp_grant.push_back(0);
    exp_byte.push_back(8'hA5);
    i_data = {8'h00, 8'hA5};
    i_req  = 2'b01;
    wait_grant(20);
    i_req = 2'b00;
    wait_idle(2000, cyc);
    checks++;
    if (cyc < 636 || cyc > 644) begin
      errors++;
      $display("FAIL frame_len: got %0d cycles expected 636..644", cyc);
    end
    check("idle_tx", 32'(o_tx), 1);
    repeat (10) @(negedge clk);

    // Contention: alternating grants from reset.
    do_reset(2);
    for (int i = 0; i < 2; i++) begin
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      exp_byte.push_back(8'h11);
      exp_byte.push_back(8'h22);
    end
    i_data = {8'h22, 8'h11};
    i_req  = 2'b11;
    for (int g = 0; g < 4; g++) wait_grant(2000);
    i_req = 2'b00;
    wait_idle(2000, cyc);
    repeat (10) @(negedge clk);

    // Reset in the 4th data bit aborts the frame; requester 0 wins afterwards.
    exp_grant.push_back(0);
    i_data = {8'h00, 8'h3C};
    i_req  = 2'b01;
    wait_grant(20);
    i_req = 2'b00;
    repeat (280) @(negedge clk);
    exp_grant.push_back(0);
    exp_byte.push_back(8'h5A);
    i_data = {8'h77, 8'h5A};
    do_reset(1);
    i_req = 2'b11;
    @(negedge clk);
    check("abort_tx", 32'(o_tx), 1);
    check("abort_busy", 32'(o_busy), 0);
    check("abort_grant", 32'(o_grant), 0);
    wait_grant(20);
    i_req = 2'b00;
    wait_idle(2000, cyc);
    repeat (10) @(negedge clk);

    // Stalled tick holds the start bit, then the frame completes.
    exp_grant.push_back(1);
    exp_byte.push_back(8'hC3);
    i_data = {8'hC3, 8'h00};
    i_req  = 2'b10;
    wait_grant(20);
    i_req   = 2'b00;
    tick_en = 1'b0;
    held    = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (o_tx !== 1'b0 || o_busy !== 1'b1) held = 1'b0;
    end
    check("stall_hold", 32'(held), 1);
    tick_en = 1'b1;
    wait_idle(2000, cyc);
    repeat (10) @(negedge clk);

    // Withdrawn request during another frame produces nothing.
    exp_grant.push_back(0);
    exp_byte.push_back(8'h96);
    i_data = {8'h00, 8'h96};
    i_req  = 2'b01;
    wait_grant(20);
    i_req = 2'b00;
    repeat (40) @(negedge clk);
    i_data = {8'h77, 8'h96};
    i_req  = 2'b10;
    repeat (10) @(negedge clk);
    i_req = 2'b00;
    wait_idle(2000, cyc);
    repeat (700) @(negedge clk);
    check("idle_after_withdraw", 32'(o_busy), 0);

    check("grants_left", 32'(exp_grant.size()), 0);
    check("bytes_left", 32'(exp_byte.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmit line between N_REQ requesters using round-robin arbitration.
- Serialises the granted byte as an 8N1 frame, timed entirely by the 16x oversampling tick from the baud-rate generator.
- Sits between the baud generator and the clients that send bytes to the host, for example the result path and status/echo path.
- Owns the tick-to-bit sequencing: start bit, data bits, stop bit.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- NB_DATA, 8, data bits per frame.
- OVERSAMPLE, 16, ticks per start/data bit.
- SB_TICK, 16, ticks for the stop bit (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_tick  input  1  one-cycle pulse at OVERSAMPLE x baud rate, from the baud generator.
- i_req  input  N_REQ  per-requester send request; level, held until granted.
- i_data  input  N_REQ*NB_DATA  flattened bytes; requester k uses bits [k*NB_DATA +: NB_DATA].
- o_grant  output  N_REQ  one-hot, one-cycle pulse; the byte was captured.
- o_owner  output  clog2(N_REQ) (min 1)  index of last granted requester.
- o_busy  output  1  high while a frame is in progress.
- o_tx  output  1  serial line, idle high.

Behaviour:
- Reset state (i_reset, synchronous, active-high; clock i_clock):
  - o_tx=1, o_busy=0, o_grant=0, o_owner=0.
  - Round-robin pointer=0, state=IDLE, tick and bit counters=0.
  - Reset wins over every other event in the same cycle.
- Reset mid-frame: the frame is aborted. Next cycle o_tx=1 and o_busy=0. No grant is issued and the byte is not resumed.
- Registers: all outputs are registered; o_busy equals (state != IDLE).
- IDLE:
  - o_tx=1; ticks are ignored.
  - If any i_req bit is set, the winner is the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - On that clock edge: capture the winner's i_data into the shift register, pulse o_grant[winner] for exactly one cycle, set o_owner=winner, set pointer=(winner+1) mod N_REQ, go to START.
- START: o_tx=0. Counts i_tick pulses; after OVERSAMPLE ticks, clear the counter and go to DATA.
- DATA:
  - o_tx = shift register bit 0, so bits go out LSB first.
  - Every OVERSAMPLE ticks: shift right and increment the bit counter.
  - After NB_DATA bits, go to STOP.
- STOP: o_tx=1. After SB_TICK ticks, go to IDLE.
- Frame length: exactly OVERSAMPLE*(1+NB_DATA)+SB_TICK ticks. The first counted tick is the first i_tick strictly after the state entry edge.
- Back-to-back frames: at least one cycle in IDLE separates frames. A pending request is granted on the first IDLE cycle.
- Requester contract:
  - Hold i_req and i_data stable until its o_grant pulse.
  - Deassert i_req in the grant cycle, or one cycle later at most. A request still high after that is treated as a new send.
- Withdrawn request: if i_req drops before grant, nothing is sent and no grant is issued.
- o_owner retains its value after the frame ends.
- Input changes: i_data and i_req changes during a frame have no effect on the frame in flight.
- No ticks: if i_tick never pulses, the FSM holds its state and o_tx level indefinitely.
- Counter width: clog2(max(OVERSAMPLE, SB_TICK))+1 bits; no wrap within a bit period.

Test Plan:
- Bench setup for all scenarios: i_tick pulses every 4 cycles unless stated.
- Single send: i_req=2'b01, i_data[7:0]=8'hA5.
  - o_grant=2'b01 for one cycle and o_owner=0.
  - o_tx bit periods of 16 ticks each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - Then o_busy=0.
- Frame timing: from o_grant to o_busy falling is 640 cycles ±4 (160 ticks), with NB_DATA=8 and SB_TICK=16.
- Contention/fairness: from reset, i_req=2'b11 held continuously (re-asserted after each grant), data 8'h11/8'h22.
  - Grants alternate 0,1,0,1.
  - Serial bytes decode as 11,22,11,22.
- Reset mid-frame: assert i_reset for 1 cycle during the 4th data bit.
  - Next cycle: o_tx=1, o_busy=0, o_grant=0.
  - With i_req=2'b11 after reset, requester 0 is granted first.
- Stalled tick: i_tick=0 after a grant.
  - o_tx=0 and o_busy=1 are held for 1000 cycles.
  - When ticks resume, the frame completes normally.
- Withdrawal: requester 1 raises i_req for 10 cycles while requester 0's frame is in progress, then drops it.
  - No o_grant[1] is issued.
  - Only one frame appears on o_tx.
